// File: rtl/graph_pkg.sv
// Shared constants, types and helpers for the feature extractor graph stores.
// The ring store uses the state enum and the modular bank-index helper.
package graph_pkg;

  localparam int PRECISION         = 8;
  localparam int FEATURE_EDGE_BITS = 18;

  typedef enum logic [1:0] {
    RING_INIT,
    RING_IDLE,
    RING_CLEAR
  } ring_state_t;

  // Bank index arithmetic on the ring; tolerates negative offsets.
  function automatic int ring_wrap(input int value, input int n);
    int r;
    r = value % n;
    if (r < 0) r = r + n;
    return r;
  endfunction

endpackage

// File: rtl/feature_ring_clear_fsm.sv
// Ring pointer, clearing engine and rotate handshake for the feature ring.
// Produces the per-bank port-A enable / write / zero-select vectors.
module feature_ring_clear_fsm
  import graph_pkg::*;
#(
  parameter int NUM_BANKS  = 3,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int PTR_W      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_in_ena,
  input  logic                  i_in_wea,
  input  logic                  i_rotate_req,
  output logic                  o_rotate_ready,
  output logic                  o_out_switch,
  output logic [PTR_W-1:0]      o_ptr,
  output logic [ADDR_WIDTH-1:0] o_clr_addr,
  output ring_state_t           o_state,
  output logic [NUM_BANKS-1:0]  o_a_en,
  output logic [NUM_BANKS-1:0]  o_a_we,
  output logic [NUM_BANKS-1:0]  o_a_zero
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  ring_state_t           r_state, w_state_nxt;
  logic [PTR_W-1:0]      r_ptr, w_ptr_nxt, w_succ;
  logic [ADDR_WIDTH-1:0] r_clr_addr, w_clr_nxt;
  logic                  r_switch, w_accept, w_in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= RING_INIT;
      r_ptr      <= '0;
      r_clr_addr <= '0;
      r_switch   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_clr_addr <= w_clr_nxt;
      r_switch   <= w_accept;
    end
  end

  // Rotate handshake: a rotation is taken on any edge where rotate_req and
  // rotate_ready are both high; the requester holds rotate_req until then.
  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_clr_nxt      = r_clr_addr;
    w_accept       = 1'b0;
    w_in_ready     = 1'b0;
    o_rotate_ready = 1'b0;
    o_a_en         = '0;
    o_a_we         = '0;
    o_a_zero       = '0;
    w_succ         = PTR_W'(ring_wrap(int'(r_ptr) + 1, NUM_BANKS));
    case (r_state)
      RING_INIT: begin
        o_a_en   = '1;
        o_a_we   = '1;
        o_a_zero = '1;
        if (r_clr_addr == LAST_ADDR) begin
          w_state_nxt = RING_IDLE;
          w_clr_nxt   = '0;
        end else begin
          w_clr_nxt = r_clr_addr + 1'b1;
        end
      end
      RING_IDLE: begin
        w_in_ready     = 1'b1;
        o_rotate_ready = 1'b1;
        if (i_rotate_req) begin
          w_accept    = 1'b1;
          w_ptr_nxt   = w_succ;
          w_state_nxt = RING_CLEAR;
          w_clr_nxt   = '0;
        end
      end
      RING_CLEAR: begin
        // r_ptr already holds the post-rotation value, so w_succ is ptr+1.
        w_in_ready       = 1'b1;
        o_a_en[w_succ]   = 1'b1;
        o_a_we[w_succ]   = 1'b1;
        o_a_zero[w_succ] = 1'b1;
        if (r_clr_addr == LAST_ADDR) begin
          w_state_nxt = RING_IDLE;
          w_clr_nxt   = '0;
        end else begin
          w_clr_nxt = r_clr_addr + 1'b1;
        end
      end
      default: begin
        w_state_nxt = RING_INIT;
        w_clr_nxt   = '0;
      end
    endcase
    if (w_in_ready && i_in_ena) begin
      o_a_en[r_ptr] = 1'b1;
      o_a_we[r_ptr] = i_in_wea;
    end
  end

  assign o_out_switch = r_switch;
  assign o_ptr        = r_ptr;
  assign o_clr_addr   = r_clr_addr;
  assign o_state      = r_state;

endmodule

// File: rtl/feature_ring_dpram.sv
// Simple dual-port memory: port A read/write (read-first), port B read-only.
// Output registers clear asynchronously so downstream sees zero during reset.
module feature_ring_dpram #(
  parameter int    DATA_WIDTH = 8,
  parameter int    ADDR_WIDTH = 4,
  parameter int    DEPTH      = 16,
  parameter string RAM_TYPE   = "block"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_a_en,
  input  logic                  i_a_we,
  input  logic [ADDR_WIDTH-1:0] i_a_addr,
  input  logic [DATA_WIDTH-1:0] i_a_din,
  output logic [DATA_WIDTH-1:0] o_a_dout,
  input  logic                  i_b_en,
  input  logic [ADDR_WIDTH-1:0] i_b_addr,
  output logic [DATA_WIDTH-1:0] o_b_dout
);

  if (RAM_TYPE != "block" && RAM_TYPE != "distributed") begin : g_bad_ram_type
    $error("feature_ring_dpram: unsupported RAM_TYPE");
  end

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_a_en && i_a_we) r_mem[i_a_addr] <= i_a_din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_a_dout <= '0;
      o_b_dout <= '0;
    end else begin
      if (i_a_en) o_a_dout <= r_mem[i_a_addr];
      if (i_b_en) o_b_dout <= r_mem[i_b_addr];
    end
  end

endmodule

// File: rtl/feature_memory_ring.sv
// N-bank rotating feature/edge store: one write bank, NUM_BANKS-2 parallel
// read windows and one bank being zeroed, advanced by a rotate handshake.
module feature_memory_ring
  import graph_pkg::*;
#(
  parameter int GRAPH_SIZE  = 32,
  parameter int PRECISION   = graph_pkg::PRECISION,
  parameter int FEATURE_DIM = 16,
  parameter int EDGE_BITS   = graph_pkg::FEATURE_EDGE_BITS,
  parameter int DATA_WIDTH  = FEATURE_DIM * PRECISION + EDGE_BITS,
  parameter int DEPTH       = GRAPH_SIZE * GRAPH_SIZE,
  parameter int ADDR_WIDTH  = $clog2(DEPTH),
  parameter int NUM_BANKS   = 3,
  parameter int NUM_READ    = NUM_BANKS - 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_WIDTH-1:0]          in_addr,
  input  logic                           in_ena,
  input  logic                           in_wea,
  input  logic [DATA_WIDTH-1:0]          in_write,
  output logic [DATA_WIDTH-1:0]          in_read,
  output logic                           in_ready,
  input  logic [ADDR_WIDTH-1:0]          out_addr,
  input  logic                           out_ren,
  output logic [NUM_READ*DATA_WIDTH-1:0] out_read,
  input  logic                           rotate_req,
  output logic                           rotate_ready,
  output logic                           out_switch,
  output logic [$clog2(NUM_BANKS)-1:0]   bank_ptr
);

  localparam int PTR_W = $clog2(NUM_BANKS);

  if (NUM_BANKS < 3) begin : g_bad_num_banks
    $error("feature_memory_ring: NUM_BANKS must be at least 3");
  end

  logic [PTR_W-1:0]      w_ptr;
  logic [ADDR_WIDTH-1:0] w_clr_addr;
  ring_state_t           w_state;
  logic [NUM_BANKS-1:0]  w_a_en, w_a_we, w_a_zero, w_b_en;
  logic [DATA_WIDTH-1:0] w_dout_a [NUM_BANKS];
  logic [DATA_WIDTH-1:0] w_dout_b [NUM_BANKS];
  logic [PTR_W-1:0]      r_map [NUM_READ];
  logic [PTR_W-1:0]      r_in_sel;

  feature_ring_clear_fsm #(
    .NUM_BANKS  (NUM_BANKS),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .PTR_W      (PTR_W)
  ) u_fsm (
    .clk            (clk),
    .reset          (reset),
    .i_in_ena       (in_ena),
    .i_in_wea       (in_wea),
    .i_rotate_req   (rotate_req),
    .o_rotate_ready (rotate_ready),
    .o_out_switch   (out_switch),
    .o_ptr          (w_ptr),
    .o_clr_addr     (w_clr_addr),
    .o_state        (w_state),
    .o_a_en         (w_a_en),
    .o_a_we         (w_a_we),
    .o_a_zero       (w_a_zero)
  );

  assign in_ready = (w_state != RING_INIT);
  assign bank_ptr = w_ptr;

  // Only the read windows see port B; write and clearing banks stay idle.
  always_comb begin
    w_b_en = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      w_b_en[PTR_W'(ring_wrap(int'(w_ptr) - 1 - k, NUM_BANKS))] = out_ren;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [ADDR_WIDTH-1:0] w_a_addr;
    logic [DATA_WIDTH-1:0] w_a_din;
    assign w_a_addr = w_a_zero[b] ? w_clr_addr : in_addr;
    assign w_a_din  = w_a_zero[b] ? '0 : in_write;

    feature_ring_dpram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH),
      .RAM_TYPE   ("block")
    ) u_ram (
      .clk      (clk),
      .reset    (reset),
      .i_a_en   (w_a_en[b]),
      .i_a_we   (w_a_we[b]),
      .i_a_addr (w_a_addr),
      .i_a_din  (w_a_din),
      .o_a_dout (w_dout_a[b]),
      .i_b_en   (w_b_en[b]),
      .i_b_addr (out_addr),
      .o_b_dout (w_dout_b[b])
    );
  end

  // The slice mapping travels with the read address so a rotation between
  // request and return cannot re-route the returned data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_READ; k++) r_map[k] <= '0;
      r_in_sel <= '0;
    end else begin
      if (out_ren) begin
        for (int k = 0; k < NUM_READ; k++) begin
          r_map[k] <= PTR_W'(ring_wrap(int'(w_ptr) - 1 - k, NUM_BANKS));
        end
      end
      if (in_ready && in_ena && !in_wea) r_in_sel <= w_ptr;
    end
  end

  always_comb begin
    out_read = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      out_read[k*DATA_WIDTH +: DATA_WIDTH] = w_dout_b[r_map[k]];
    end
  end

  assign in_read = w_dout_a[r_in_sel];

endmodule

// File: tb/tb_feature_memory_ring.sv
// Directed bench for feature_memory_ring: a 3-bank and a 5-bank ring with
// GRAPH_SIZE=4 (DEPTH=16), checked against hand-derived values.
module tb_feature_memory_ring;
  import graph_pkg::*;

  localparam int AW = 4;
  localparam int DW = 16 * PRECISION + FEATURE_EDGE_BITS;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // 3-bank ring
  logic [AW-1:0] in_addr, out_addr;
  logic          in_ena, in_wea, out_ren, rotate_req;
  logic [DW-1:0] in_write, in_read, out_read;
  logic          in_ready, rotate_ready, out_switch;
  logic [1:0]    bank_ptr;

  // 5-bank ring
  logic [AW-1:0]   in_addr_5, out_addr_5;
  logic            in_ena_5, in_wea_5, out_ren_5, rotate_req_5;
  logic [DW-1:0]   in_write_5, in_read_5;
  logic [3*DW-1:0] out_read_5;
  logic            in_ready_5, rotate_ready_5, out_switch_5;
  logic [2:0]      bank_ptr_5;

  int checks = 0;
  int errors = 0;
  int sw_count;
  logic [DW-1:0] pat_a, pat_s, pat_q, pat_t;
  logic [DW-1:0] tags [4];

  feature_memory_ring #(.GRAPH_SIZE(4), .NUM_BANKS(3)) dut (
    .clk(clk), .reset(reset),
    .in_addr(in_addr), .in_ena(in_ena), .in_wea(in_wea), .in_write(in_write),
    .in_read(in_read), .in_ready(in_ready),
    .out_addr(out_addr), .out_ren(out_ren), .out_read(out_read),
    .rotate_req(rotate_req), .rotate_ready(rotate_ready),
    .out_switch(out_switch), .bank_ptr(bank_ptr)
  );

  feature_memory_ring #(.GRAPH_SIZE(4), .NUM_BANKS(5)) dut5 (
    .clk(clk), .reset(reset),
    .in_addr(in_addr_5), .in_ena(in_ena_5), .in_wea(in_wea_5), .in_write(in_write_5),
    .in_read(in_read_5), .in_ready(in_ready_5),
    .out_addr(out_addr_5), .out_ren(out_ren_5), .out_read(out_read_5),
    .rotate_req(rotate_req_5), .rotate_ready(rotate_ready_5),
    .out_switch(out_switch_5), .bank_ptr(bank_ptr_5)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rot5();
    rotate_req_5 = 1'b1;
    step();
    rotate_req_5 = 1'b0;
    repeat (16) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_addr = '0; out_addr = '0; in_ena = 0; in_wea = 0; out_ren = 0;
    rotate_req = 0; in_write = '0;
    in_addr_5 = '0; out_addr_5 = '0; in_ena_5 = 0; in_wea_5 = 0; out_ren_5 = 0;
    rotate_req_5 = 0; in_write_5 = '0;
    pat_a = DW'({19{8'hA5}});
    pat_s = DW'({19{8'h3C}});
    pat_q = DW'({19{8'h5A}});
    pat_t = DW'({19{8'hE7}});
    for (int e = 0; e < 4; e++) tags[e] = DW'(64'hC0DE_0000_0000_0000 + e + 1);

    // reset values
    step(); step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_rotate_ready", rotate_ready, 0);
    chk("rst_out_switch", out_switch, 0);
    chk("rst_in_read", in_read, 0);
    chk("rst_out_read", out_read, 0);
    chk("rst_bank_ptr", bank_ptr, 0);

    // INIT lasts exactly 16 cycles
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("init_in_ready_low", in_ready, 0);
      step();
    end
    chk("init_done_in_ready", in_ready, 1);
    chk("init_done_rotate_ready", rotate_ready, 1);
    chk("init_done_bank_ptr", bank_ptr, 0);

    // every address of write bank and read window reads zero
    for (int a = 0; a < 16; a++) begin
      in_addr = AW'(a); in_ena = 1; in_wea = 0;
      out_addr = AW'(a); out_ren = 1;
      step();
      chk("zero_in_read", in_read, 0);
      chk("zero_out_read", out_read, 0);
    end
    in_ena = 0; out_ren = 0;

    // write 0xA5.. at addr 3, read back, rotate
    in_ena = 1; in_wea = 1; in_addr = 3; in_write = pat_a;
    step();
    in_wea = 0;
    step();
    chk("wr_readback", in_read, pat_a);
    in_ena = 0;
    rotate_req = 1;
    step();
    rotate_req = 0;
    chk("rot1_bank_ptr", bank_ptr, 1);
    chk("rot1_switch", out_switch, 1);
    chk("rot1_rotate_ready", rotate_ready, 0);
    sw_count = 1;
    for (int i = 0; i < 15; i++) begin
      step();
      sw_count += int'(out_switch);
    end
    chk("clear_busy", rotate_ready, 0);
    step();
    sw_count += int'(out_switch);
    chk("clear_done", rotate_ready, 1);
    chk("switch_pulses", sw_count, 1);
    out_addr = 3; out_ren = 1;
    step();
    chk("read_window0", out_read, pat_a);
    out_ren = 0;
    in_addr = 3; in_ena = 1; in_wea = 0;
    step();
    chk("new_bank_zero", in_read, 0);
    in_ena = 0;

    // rotate_req held high: accepts 17 cycles apart
    rotate_req = 1;
    step();
    chk("held_ptr2", bank_ptr, 2);
    chk("held_switch1", out_switch, 1);
    in_ena = 1; in_wea = 1; in_addr = 5; in_write = pat_s;
    step();
    in_ena = 0;
    repeat (15) step();
    chk("held_ptr_still2", bank_ptr, 2);
    chk("held_ready_again", rotate_ready, 1);
    chk("held_no_switch", out_switch, 0);
    step();
    chk("held_wrap_ptr0", bank_ptr, 0);
    chk("held_switch2", out_switch, 1);
    rotate_req = 0;
    repeat (16) step();
    chk("held_clear_done", rotate_ready, 1);
    in_addr = 3; in_ena = 1; in_wea = 0;
    step();
    chk("old_data_cleared", in_read, 0);
    in_ena = 0;
    out_addr = 5; out_ren = 1;
    step();
    chk("clear_write_kept", out_read, pat_s);
    out_ren = 0;

    // read and write on the rotation cycle use the pre-rotation mapping
    in_ena = 1; in_wea = 1; in_addr = 5; in_write = pat_q;
    step();
    rotate_req = 1; out_addr = 5; out_ren = 1;
    in_ena = 1; in_wea = 1; in_addr = 6; in_write = pat_t;
    step();
    rotate_req = 0; in_ena = 0;
    chk("rot_cycle_read", out_read, pat_s);
    chk("rot_cycle_ptr", bank_ptr, 1);
    step();
    chk("post_rot_read", out_read, pat_q);
    out_addr = 6;
    step();
    chk("rot_cycle_write_old", out_read, pat_t);
    out_ren = 0;
    in_ena = 1; in_wea = 0; in_addr = 6;
    step();
    chk("rot_cycle_write_not_new", in_read, 0);
    in_ena = 0;

    // reset in the middle of CLEAR at clr_addr=7
    repeat (13) step();
    chk("pre_reset_ready", rotate_ready, 1);
    rotate_req = 1;
    step();
    rotate_req = 0;
    chk("pre_reset_ptr", bank_ptr, 2);
    repeat (7) step();
    reset = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_rotate_ready", rotate_ready, 0);
    chk("midrst_out_switch", out_switch, 0);
    chk("midrst_bank_ptr", bank_ptr, 0);
    chk("midrst_in_read", in_read, 0);
    chk("midrst_out_read", out_read, 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("reinit_in_ready_low", in_ready, 0);
      step();
    end
    chk("reinit_in_ready", in_ready, 1);
    chk("reinit_bank_ptr", bank_ptr, 0);
    out_addr = 5; out_ren = 1;
    in_addr = 5; in_ena = 1; in_wea = 0;
    step();
    chk("rezero_read_bank", out_read, 0);
    chk("rezero_write_bank", in_read, 0);
    out_ren = 0; in_ena = 0;

    // 5-bank ring: three read windows, newest first
    chk("ring5_ready", in_ready_5, 1);
    for (int e = 0; e < 3; e++) begin
      in_ena_5 = 1; in_wea_5 = 1; in_addr_5 = 0; in_write_5 = tags[e];
      step();
      in_ena_5 = 0;
      rot5();
    end
    chk("ring5_ptr3", bank_ptr_5, 3);
    out_addr_5 = 0; out_ren_5 = 1;
    step();
    chk("ring5_e3_slice0", out_read_5[0*DW +: DW], tags[2]);
    chk("ring5_e3_slice1", out_read_5[1*DW +: DW], tags[1]);
    chk("ring5_e3_slice2", out_read_5[2*DW +: DW], tags[0]);
    out_ren_5 = 0;
    in_ena_5 = 1; in_wea_5 = 1; in_addr_5 = 0; in_write_5 = tags[3];
    step();
    in_ena_5 = 0;
    rot5();
    chk("ring5_ptr4", bank_ptr_5, 4);
    out_ren_5 = 1;
    step();
    chk("ring5_e4_slice0", out_read_5[0*DW +: DW], tags[3]);
    chk("ring5_e4_slice1", out_read_5[1*DW +: DW], tags[2]);
    chk("ring5_e4_slice2", out_read_5[2*DW +: DW], tags[1]);
    out_ren_5 = 0;
    rot5();
    chk("ring5_wrap_ptr0", bank_ptr_5, 0);
    in_ena_5 = 1; in_wea_5 = 0; in_addr_5 = 0;
    step();
    chk("ring5_oldest_cleared", in_read_5, 0);
    in_ena_5 = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/feature_memory_ring.md
Name: feature_memory_ring

Overview:
- N-bank rotating feature/edge store for the feature extractor; successor to the fixed 3-bank ping-pong store.
- Banks form a ring:
  - one write bank, owned by the graph builder;
  - NUM_BANKS-2 read banks, readable in parallel by the convolution stage;
  - one clearing bank, zeroed by an internal engine.
- Rotation is a handshake, accepted only once the clearing bank is fully zeroed.
- After reset, all banks are zeroed before any traffic is accepted.

Parameters:
- GRAPH_SIZE, 32, graph side length in nodes.
- PRECISION, graph_pkg::PRECISION, bits per feature element.
- FEATURE_DIM, 16, features per node.
- EDGE_BITS, 18, edge-flag bits per word.
- DATA_WIDTH, FEATURE_DIM*PRECISION+EDGE_BITS, word width.
- DEPTH, GRAPH_SIZE*GRAPH_SIZE, words per bank.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- NUM_BANKS, 3, ring size; must be at least 3 (elaboration assertion).
- NUM_READ, NUM_BANKS-2, number of parallel read windows.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- in_addr  in  ADDR_WIDTH  write-bank address.
- in_ena  in  1  write-bank access enable.
- in_wea  in  1  write enable; a read when low.
- in_write  in  DATA_WIDTH  write data.
- in_read  out  DATA_WIDTH  write-bank read data.
- in_ready  out  1  write-side accesses accepted.
- out_addr  in  ADDR_WIDTH  shared read address for all read banks.
- out_ren  in  1  read enable.
- out_read  out  NUM_READ*DATA_WIDTH  read data; slice 0 is the newest bank (ptr-1), slice k is bank ptr-1-k.
- rotate_req  in  1  request to advance the ring.
- rotate_ready  out  1  rotation can be accepted this cycle.
- out_switch  out  1  one-cycle pulse after a rotation.
- bank_ptr  out  $clog2(NUM_BANKS)  current write-bank index.

Behaviour:
- Bank mapping, all indices mod NUM_BANKS:
  - write bank = ptr;
  - read window k = ptr-1-k, for k in 0..NUM_READ-1;
  - clearing bank = ptr+1.
- Reset (asynchronous):
  - ptr=0, clr_addr=0, state=INIT.
  - in_ready=0, rotate_ready=0, out_switch=0, in_read=0, out_read=0.
- INIT:
  - Port A of every bank writes zero at clr_addr, with clr_addr incrementing each cycle.
  - in_ena is ignored.
  - At clr_addr==DEPTH-1 the state goes to IDLE and clr_addr returns to 0.
  - Duration is DEPTH cycles.
- IDLE:
  - in_ready=1 and rotate_ready=1.
  - rotate_req && rotate_ready is the accepting edge: ptr<=ptr+1 mod NUM_BANKS, state<=CLEAR, clr_addr<=0, out_switch=1 in the next cycle.
- CLEAR:
  - Port A of the clearing bank (computed from the updated ptr) writes zero at clr_addr each cycle.
  - in_ready=1 and rotate_ready=0; rotate_req is ignored, and the requester must hold it.
  - At clr_addr==DEPTH-1 the state goes to IDLE.
- Write side:
  - Port A of the write bank; read-first.
  - in_read is valid 1 cycle after in_ena && !in_wea.
  - An access in the same cycle as an accepted rotation targets the old write bank.
  - in_ena while in_ready=0 is dropped, with no memory side effect.
- Read side:
  - Port B of each read bank; latency 1.
  - The bank-to-slice mapping is registered together with the address, so data returned at t+1 reflects the mapping at t even across a rotation.
  - out_read holds its value when out_ren=0.
  - The clearing bank's port B is disabled.
- Wrap-around: ptr wraps NUM_BANKS-1 -> 0; clr_addr stops at DEPTH-1 and never overruns.
- Reset mid-operation (INIT, CLEAR or a rotation): ring returns to ptr=0 and INIT; all banks are re-zeroed.
- Data is never silently lost: a written bank is zeroed only after it has served as read window NUM_READ-1 for at least one epoch.

Decomposition:
- graph_pkg:
  - add FEATURE_EDGE_BITS=18;
  - add typedef enum {RING_INIT, RING_IDLE, RING_CLEAR} ring_state_t.
- Sub-module feature_ring_clear_fsm:
  - contains ptr, state, clr_addr, rotate handshake and out_switch;
  - outputs the per-bank port-A enable, write and zero-select vectors.
- Top level: NUM_BANKS instances of the existing dual-port memory (RAM_TYPE "block"), plus mux/demux and the registered read mapping.

Test Plan (GRAPH_SIZE=4 so DEPTH=16; NUM_BANKS=3 unless noted):
- Reset released: in_ready=0 for exactly 16 cycles, then in_ready=1 and rotate_ready=1; reading any address of any bank returns 0.
- Write 0xA5.. at addr 3, rotate, wait 16 cycles: out_addr=3 gives out_read slice0 = 0xA5.. one cycle later; bank_ptr=1; out_switch pulsed exactly once.
- rotate_req held high continuously: rotations accepted every 17 cycles (1 accept + 16 clear); bank_ptr sequence 0,1,2,0; each new write bank reads back all zeros.
- NUM_BANKS=5: write a distinct tag to addr 0 of each of 4 epochs: slices 0..2 show tags newest to oldest; the oldest tag is cleared after the 4th rotation.
- out_addr issued in the same cycle as a rotation: returned data comes from the pre-rotation mapping; a write on that cycle lands in the old bank.
- reset asserted midway through CLEAR at clr_addr=7: outputs go to their reset values immediately, followed by a full 16-cycle INIT and bank_ptr=0.
